// File: rtl/load_store_unit_if.sv
// load_store_unit_if: CPU request/response handshake and byte-lane memory port of the LSU
interface load_store_unit_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_WORDS_LOG2 = 8
);
   logic                      req_valid, req_ready, req_we;
   logic [2:0]                req_funct3;
   logic [ADDR_WIDTH-1:0]     req_addr;
   logic [31:0]               req_wdata;
   logic                      rsp_valid, rsp_ready, rsp_err;
   logic [31:0]               rsp_rdata;
   logic                      mem_en, mem_we;
   logic [MEM_WORDS_LOG2-1:0] mem_addr;
   logic [3:0]                mem_be;
   logic [31:0]               mem_wdata, mem_rdata;
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_be, mem_wdata
   );
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit over a byte-lane memory with 1-cycle synchronous read.
// Define LSU_MISALIGNED_EN to execute word-crossing accesses as two memory cycles;
// without it such accesses fault without touching memory.
module load_store_unit #(
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_WORDS_LOG2 = 8
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave bus
);
`ifdef LSU_MISALIGNED_EN
   localparam bit MISALIGNED_EN = 1'b1;
`else
   localparam bit MISALIGNED_EN = 1'b0;
`endif
   typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAPT, RESP} state_t;
   state_t                    r_state;
   logic [MEM_WORDS_LOG2+1:0] r_addr, w_addr;
   logic                      r_we, w_we;
   logic [2:0]                r_f3, w_f3, w_size;
   logic [31:0]               r_wdata, w_wdata, r_rd0, w_raw, w_ext;
   logic [1:0]                w_off;
   logic [3:0]                w_mask;
   logic [7:0]                w_be;
   logic [63:0]               w_wd, w_rd;
   logic [MEM_WORDS_LOG2-1:0] w_widx;
   logic                      w_split, w_legal, w_fault;

   // Decode the live request while IDLE so ACC0 outputs register at the accepting edge
   always_comb begin
      w_addr  = r_state == IDLE ? bus.req_addr[MEM_WORDS_LOG2+1:0] : r_addr;
      w_we    = r_state == IDLE ? bus.req_we : r_we;
      w_f3    = r_state == IDLE ? bus.req_funct3 : r_f3;
      w_wdata = r_state == IDLE ? bus.req_wdata : r_wdata;
      w_off   = w_addr[1:0];
      w_widx  = w_addr[MEM_WORDS_LOG2+1:2];
      w_size  = w_f3[1:0] == 2'd0 ? 3'd1 : w_f3[1:0] == 2'd1 ? 3'd2 : 3'd4;
      w_mask  = w_f3[1:0] == 2'd0 ? 4'b0001 : w_f3[1:0] == 2'd1 ? 4'b0011 : 4'b1111;
      w_be    = {4'h0, w_mask} << w_off;
      w_wd    = {32'h0, w_wdata} << {w_off, 3'b000};
      w_split = ({1'b0, w_off} + w_size) > 3'd4;
      w_legal = w_f3[1:0] != 2'b11 && (w_we ? !w_f3[2] : !(w_f3[2] && w_f3[1]));
      w_fault = !w_legal || (w_split && !MISALIGNED_EN);
      w_rd    = w_split ? {bus.mem_rdata, r_rd0} : {32'h0, bus.mem_rdata};
      w_raw   = 32'(w_rd >> {w_off, 3'b000});
      w_ext   = w_f3 == 3'b000 ? {{24{w_raw[7]}}, w_raw[7:0]} :
                w_f3 == 3'b001 ? {{16{w_raw[15]}}, w_raw[15:0]} :
                w_f3 == 3'b100 ? {24'h0, w_raw[7:0]} :
                w_f3 == 3'b101 ? {16'h0, w_raw[15:0]} : w_raw;
   end

   // Transaction FSM with registered handshake and memory outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_addr        <= '0;
         r_we          <= 1'b0;
         r_f3          <= 3'b0;
         r_wdata       <= 32'h0;
         r_rd0         <= 32'h0;
         bus.req_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 32'h0;
         bus.rsp_err   <= 1'b0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_be    <= 4'h0;
         bus.mem_wdata <= 32'h0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  r_addr        <= w_addr;
                  r_we          <= w_we;
                  r_f3          <= w_f3;
                  r_wdata       <= w_wdata;
                  bus.req_ready <= 1'b0;
                  if (w_fault) begin
                     r_state       <= RESP;
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_rdata <= 32'h0;
                  end else begin
                     r_state       <= ACC0;
                     bus.mem_en    <= 1'b1;
                     bus.mem_we    <= w_we;
                     bus.mem_addr  <= w_widx;
                     bus.mem_be    <= w_be[3:0];
                     bus.mem_wdata <= w_wd[31:0];
                  end
               end else begin
                  bus.req_ready <= 1'b1;
               end
            end
            ACC0: begin
               if (w_split) begin
                  r_state       <= ACC1;
                  bus.mem_addr  <= w_widx + MEM_WORDS_LOG2'(1);
                  bus.mem_be    <= w_be[7:4];
                  bus.mem_wdata <= w_wd[63:32];
               end else begin
                  r_state    <= CAPT;
                  bus.mem_en <= 1'b0;
                  bus.mem_we <= 1'b0;
                  bus.mem_be <= 4'h0;
               end
            end
            ACC1: begin
               r_state    <= CAPT;
               r_rd0      <= bus.mem_rdata;
               bus.mem_en <= 1'b0;
               bus.mem_we <= 1'b0;
               bus.mem_be <= 4'h0;
            end
            CAPT: begin
               r_state       <= RESP;
               bus.rsp_valid <= 1'b1;
               bus.rsp_err   <= 1'b0;
               bus.rsp_rdata <= r_we ? 32'h0 : w_ext;
            end
            default: begin
               if (bus.rsp_ready) begin
                  r_state       <= IDLE;
                  bus.rsp_valid <= 1'b0;
                  bus.req_ready <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the LSU against a byte-lane memory model
module tb_load_store_unit;
   logic        clk = 1'b0, rst = 1'b1, preload = 1'b1;
   int          checks = 0, errors = 0;
   logic [31:0] mem [256];
   logic [31:0] rd, wd0;
   logic        err;
   logic [3:0]  be0;
   logic [7:0]  a0, a1;
   int          n, ens;

   load_store_unit_if bus ();
   load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Byte-lane memory, 1-cycle synchronous read, preloaded while preload=1
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++)
            mem[i] <= i == 0 ? 32'h56783412 : i == 1 ? 32'h9ABCDEF0 : 32'h0;
      end else if (bus.mem_en) begin
         bus.mem_rdata <= mem[bus.mem_addr];
         for (int i = 0; i < 4; i++)
            if (bus.mem_we && bus.mem_be[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request with rsp_ready=1; n counts edges from the accepting edge to rsp_valid
   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
      int k;
      n = 0; ens = 0; be0 = 4'h0; wd0 = 32'h0; a0 = 8'h0; a1 = 8'h0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
      bus.req_addr = addr; bus.req_wdata = wd;
      k = 0;
      while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
      @(posedge clk); #1 bus.req_valid = 1'b0;
      n = 1; k = 0;
      while (k < 20) begin
         @(negedge clk);
         if (bus.mem_en) begin
            if (ens == 0) begin be0 = bus.mem_be; wd0 = bus.mem_wdata; a0 = bus.mem_addr; end
            else a1 = bus.mem_addr;
            ens++;
         end
         if (bus.rsp_valid) break;
         @(posedge clk); n++; k++;
      end
      rd = bus.rsp_rdata; err = bus.rsp_err;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
      bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp", {29'h0, bus.rsp_valid, bus.rsp_err, 1'b0}, 32'h0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_mem_ctl", {26'h0, bus.mem_en, bus.mem_we, bus.mem_be}, 32'h0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk); preload = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

      xact(1'b0, 3'b010, 32'h0, 32'h0);
      chk("lw0_data", rd, 32'h56783412);
      chk("lw0_err", 32'(err), 32'd0);
      chk("lw0_latency", 32'(n), 32'd3);
      chk("lw0_be", 32'(be0), 32'hF);

      xact(1'b0, 3'b000, 32'h4, 32'h0);
      chk("lb4_data", rd, 32'hFFFFFFF0);
      chk("lb4_addr", 32'(a0), 32'd1);
      xact(1'b0, 3'b100, 32'h4, 32'h0);
      chk("lbu4_data", rd, 32'h000000F0);
      xact(1'b0, 3'b001, 32'h2, 32'h0);
      chk("lh2_data", rd, 32'h00005678);
      chk("lh2_be", 32'(be0), 32'hC);
      xact(1'b0, 3'b101, 32'h6, 32'h0);
      chk("lhu6_data", rd, 32'h00009ABC);

      xact(1'b0, 3'b010, 32'h2, 32'h0);
`ifdef LSU_MISALIGNED_EN
      chk("split_data", rd, 32'hDEF05678);
      chk("split_err", 32'(err), 32'd0);
      chk("split_latency", 32'(n), 32'd4);
      chk("split_accesses", 32'(ens), 32'd2);
      chk("split_addr0", 32'(a0), 32'd0);
      chk("split_addr1", 32'(a1), 32'd1);
`else
      chk("split_err", 32'(err), 32'd1);
      chk("split_data", rd, 32'h0);
      chk("split_no_mem", 32'(ens), 32'd0);
      chk("split_latency", 32'(n), 32'd1);
`endif

      bus.rsp_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b011; bus.req_addr = 32'h0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("ill_valid", 32'(bus.rsp_valid), 32'd1);
      chk("ill_err", 32'(bus.rsp_err), 32'd1);
      chk("ill_data", bus.rsp_rdata, 32'h0);
      chk("ill_mem_en", 32'(bus.mem_en), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
         chk("stall_err", 32'(bus.rsp_err), 32'd1);
         chk("stall_data", bus.rsp_rdata, 32'h0);
         chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
         chk("stall_mem_en", 32'(bus.mem_en), 32'd0);
      end
      bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release_valid", 32'(bus.rsp_valid), 32'd0);
      chk("stall_release_ready", 32'(bus.req_ready), 32'd1);

      xact(1'b1, 3'b001, 32'h1, 32'h0000ABCD);
      chk("sh1_be", 32'(be0), 32'h6);
      chk("sh1_wdata", wd0, 32'h00ABCD00);
      chk("sh1_rdata", rd, 32'h0);
      chk("sh1_err", 32'(err), 32'd0);
      xact(1'b0, 3'b010, 32'h0, 32'h0);
      chk("lw0_after_sh", rd, 32'h56ABCD12);

      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
      bus.req_addr = 32'h0; bus.req_wdata = 32'hDEADBEEF;
      @(posedge clk); #1 bus.req_valid = 1'b0;
      chk("sw_acc0_en", {30'h0, bus.mem_en, bus.mem_we}, 32'h3);
      #1 rst = 1'b0;
      #1;
      chk("rst_mid_mem_ctl", {26'h0, bus.mem_en, bus.mem_we, bus.mem_be}, 32'h0);
      chk("rst_mid_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_mid_hs", {29'h0, bus.req_ready, bus.rsp_valid, bus.rsp_err}, 32'h0);
      @(posedge clk); @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
      xact(1'b0, 3'b010, 32'h0, 32'h0);
      chk("lw0_after_rst", rd, 32'h56ABCD12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
